// File: rtl/seq_pkg.sv
// Shared types for the multi-cycle sequencer: state encoding, PC source select, latched class flags.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package seq_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        ERROR  = 3'd6
    } seq_state_t;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;

    // Instruction class captured at the end of DECODE; priority jp > br > st > ld > wr.
    typedef struct packed {
        logic jp;
        logic br;
        logic st;
        logic ld;
        logic lk;
        logic wr;
    } class_t;

endpackage

// File: rtl/seq_wait_timer.sv
// Memory wait-cycle counter shared by FETCH and MEM; expired flags the last tolerated wait cycle.
// Latency: expired is combinational on enable and the registered count.
// Backpressure: none; MEM_TIMEOUT=0 ties expired low (wait forever).
module seq_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
            localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

            logic [W-1:0] cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable && (cnt != LAST)) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // The wait cycle that would bring the count to MEM_TIMEOUT is the one that trips.
            assign expired = enable && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/multicycle_sequencer.sv
// MIPS multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB); SEQ_PERF_CNT_EN adds cycle/instr counters.
// Latency: pc_we 3 (br/j), 4 (R/I, store), 5 (load) cycles after FETCH entry, +1 per memory wait cycle.
// Backpressure: holds in FETCH/MEM until imem_rdy/dmem_rdy; MEM_TIMEOUT waits lock into ERROR.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef SEQ_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       branch,
    input  logic       jump,
    input  logic       save_pc,
    input  logic       data_mem_wren,
    input  logic       mem_to_reg,
    input  logic       reg_mem_wren,
    input  logic       branch_taken,
    input  logic       imem_rdy,
    input  logic       dmem_rdy,
    input  logic       halt_req,
    output logic       imem_req,
    output logic       ir_load,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       rf_we,
    output logic       link_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       halted,
    output logic       bus_error,
    output logic [2:0] state_o
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    seq_state_t state, next_state;
    class_t     flags;
    logic       timer_en, timer_expired, retire;
    logic       imem_req_c, ir_load_c, dmem_req_c, dmem_we_c, rf_we_c, link_we_c, pc_we_c;
    logic       halted_c, bus_error_c;
    logic [1:0] pc_src_c;

    seq_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (next_state != state),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            flags <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE) begin
                flags.jp <= jump;
                flags.br <= branch;
                flags.st <= data_mem_wren;
                flags.ld <= (mem_to_reg === 1'b1);
                flags.lk <= save_pc;
                flags.wr <= reg_mem_wren;
            end
        end
    end

    always_comb begin
        next_state  = state;
        timer_en    = 1'b0;
        retire      = 1'b0;
        imem_req_c  = 1'b0;
        ir_load_c   = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        rf_we_c     = 1'b0;
        link_we_c   = 1'b0;
        pc_src_c    = PC_SRC_SEQ;
        halted_c    = 1'b0;
        bus_error_c = 1'b0;
        case (state)
            FETCH: begin
                imem_req_c = 1'b1;
                if (imem_rdy) begin
                    ir_load_c  = 1'b1;
                    next_state = DECODE;
                end else begin
                    timer_en = 1'b1;
                    if (timer_expired) next_state = ERROR;
                end
            end
            DECODE: next_state = EXEC;
            EXEC: begin
                if (flags.jp) begin
                    retire    = 1'b1;
                    pc_src_c  = PC_SRC_JMP;
                    link_we_c = flags.lk;
                end else if (flags.br) begin
                    retire   = 1'b1;
                    pc_src_c = branch_taken ? PC_SRC_BR : PC_SRC_SEQ;
                end else if (flags.st || flags.ld) begin
                    next_state = MEM;
                end else if (flags.wr) begin
                    next_state = WB;
                end else begin
                    retire = 1'b1;
                end
            end
            MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = flags.st;
                if (dmem_rdy) begin
                    if (flags.st) retire = 1'b1;
                    else          next_state = WB;
                end else begin
                    timer_en = 1'b1;
                    if (timer_expired) next_state = ERROR;
                end
            end
            WB: begin
                rf_we_c = 1'b1;
                retire  = 1'b1;
            end
            HALT: begin
                halted_c = 1'b1;
                if (!halt_req) next_state = FETCH;
            end
            ERROR:   bus_error_c = 1'b1;
            default: next_state = FETCH;
        endcase
        pc_we_c = retire;
        // halt_req only matters at the retire boundary.
        if (retire) next_state = halt_req ? HALT : FETCH;
    end

    // Outputs are forced idle while reset is asserted, even though they decode from inputs.
    assign imem_req  = rst_n & imem_req_c;
    assign ir_load   = rst_n & ir_load_c;
    assign dmem_req  = rst_n & dmem_req_c;
    assign dmem_we   = rst_n & dmem_we_c;
    assign rf_we     = rst_n & rf_we_c;
    assign link_we   = rst_n & link_we_c;
    assign pc_we     = rst_n & pc_we_c;
    assign pc_src    = rst_n ? pc_src_c : PC_SRC_SEQ;
    assign halted    = rst_n & halted_c;
    assign bus_error = rst_n & bus_error_c;
    assign state_o   = state;

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state != HALT && state != ERROR) cycle_cnt <= cycle_cnt + 1'b1;
            if (pc_we_c) instr_cnt <= instr_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: retire records are queued per instruction and
// popped by a monitor on every pc_we; per-cycle strobes are checked inline.
module tb_multicycle_sequencer;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       branch, jump, save_pc, data_mem_wren, mem_to_reg, reg_mem_wren, branch_taken;
    logic       imem_rdy, dmem_rdy, halt_req;
    logic       imem_req, ir_load, dmem_req, dmem_we, rf_we, link_we, pc_we, halted, bus_error;
    logic [1:0] pc_src;
    logic [2:0] state_o;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        string      tag;
        int         c;
        logic [1:0] src;
        logic       rf;
        logic       lk;
    } exp_t;
    exp_t sb[$];

    multicycle_sequencer #(.MEM_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch        (branch),
        .jump          (jump),
        .save_pc       (save_pc),
        .data_mem_wren (data_mem_wren),
        .mem_to_reg    (mem_to_reg),
        .reg_mem_wren  (reg_mem_wren),
        .branch_taken  (branch_taken),
        .imem_rdy      (imem_rdy),
        .dmem_rdy      (dmem_rdy),
        .halt_req      (halt_req),
        .imem_req      (imem_req),
        .ir_load       (ir_load),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .rf_we         (rf_we),
        .link_we       (link_we),
        .pc_we         (pc_we),
        .pc_src        (pc_src),
        .halted        (halted),
        .bus_error     (bus_error),
        .state_o       (state_o)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instr_cnt     (instr_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every retire pulse must match the oldest queued instruction.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (pc_we) begin
            chk("pc_we_with_ir_load", 32'(ir_load), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pc_we", 32'(pc_we), 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_retire_cycle"}, 32'(cyc), 32'(e.c));
                chk({e.tag, "_pc_src"}, 32'(pc_src), 32'(e.src));
                chk({e.tag, "_rf_we"}, 32'(rf_we), 32'(e.rf));
                chk({e.tag, "_link_we"}, 32'(link_we), 32'(e.lk));
            end
        end else if (rf_we || link_we) begin
            chk("write_without_retire", {30'd0, rf_we, link_we}, 32'd0);
        end
    end

    task automatic idle_inputs();
        branch = 0; jump = 0; save_pc = 0; data_mem_wren = 0; mem_to_reg = 1'bz;
        reg_mem_wren = 0; branch_taken = 0; imem_rdy = 0; dmem_rdy = 0;
    endtask

    // Called at posedge+1 of the FETCH-entry cycle; returns at posedge+1 after the retire cycle.
    task automatic do_instr(input string tag, input logic j, input logic b, input logic sp,
                            input logic st, input logic ld, input logic wr, input logic bt,
                            input int iw, input int dw, input logic hq);
        int         lat;
        int         mem_k;
        logic       mem;
        exp_t       e;
        mem    = !j && !b && (st || ld);
        e.tag  = tag;
        e.src  = PC_SRC_SEQ;
        e.rf   = !j && !b && !st && (ld || wr);
        e.lk   = j && sp;
        if (j)       begin lat = 3; e.src = PC_SRC_JMP; end
        else if (b)  begin lat = 3; e.src = bt ? PC_SRC_BR : PC_SRC_SEQ; end
        else if (st) lat = 4 + dw;
        else if (ld) lat = 5 + dw;
        else if (wr) lat = 4;
        else         lat = 3;
        lat   = lat + iw;
        e.c   = cyc + lat - 1;
        sb.push_back(e);
        mem_k = iw + 4;
        jump = j; branch = b; save_pc = sp; data_mem_wren = st;
        mem_to_reg = ld ? 1'b1 : 1'bz; reg_mem_wren = wr; branch_taken = bt;
        for (int k = 1; k <= lat; k++) begin
            imem_rdy = (k == iw + 1);
            dmem_rdy = mem && (k == mem_k + dw);
            if (hq && k == mem_k) halt_req = 1'b1;
            @(negedge clk);
            chk({tag, "_ir_load"}, 32'(ir_load), 32'(k == iw + 1));
            chk({tag, "_dmem_req"}, 32'(dmem_req), 32'(mem && k >= mem_k && k <= mem_k + dw));
            chk({tag, "_dmem_we"}, 32'(dmem_we), 32'(mem && st && k >= mem_k && k <= mem_k + dw));
            @(posedge clk); #1;
        end
        idle_inputs();
        chk({tag, "_next_state"}, 32'(state_o), hq ? 32'(HALT) : 32'(FETCH));
    endtask

    initial begin
        rst_n = 1'b0;
        halt_req = 1'b0;
        idle_inputs();
        imem_rdy = 1'b1;
        dmem_rdy = 1'b1;
        #2;
        chk("reset_outputs", {21'd0, imem_req, ir_load, dmem_req, dmem_we, rf_we, link_we,
                              pc_we, pc_src, halted, bus_error}, 32'd0);
        chk("reset_state", 32'(state_o), 32'(FETCH));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle_inputs();

        do_instr("add", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
`ifdef SEQ_PERF_CNT_EN
        chk("perf_cycle_cnt", cycle_cnt, 32'd4);
        chk("perf_instr_cnt", instr_cnt, 32'd1);
`endif
        do_instr("lw_wait2", 0, 0, 0, 0, 1, 1, 0, 0, 2, 0);
        do_instr("beq_taken", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        do_instr("beq_not_taken", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_instr("jal", 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        do_instr("nop_iwait2", 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        do_instr("sw", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        do_instr("sw_halt", 0, 0, 0, 1, 0, 0, 0, 1, 2, 1);

        @(negedge clk);
        chk("halt_halted", 32'(halted), 32'd1);
        @(posedge clk); #1;
        chk("halt_hold_state", 32'(state_o), 32'(HALT));
        halt_req = 1'b0;
        @(negedge clk);
        chk("halt_still_halted", 32'(halted), 32'd1);
        @(posedge clk); #1;
        chk("halt_release_state", 32'(state_o), 32'(FETCH));
        @(negedge clk);
        chk("halt_release_halted", 32'(halted), 32'd0);

        // Load abandoned by reset while waiting in MEM.
        @(posedge clk); #1;
        mem_to_reg = 1'b1; reg_mem_wren = 1'b1; imem_rdy = 1'b1;
        @(posedge clk); #1;
        imem_rdy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_mem_dmem_req", 32'(dmem_req), 32'd1);
        imem_rdy = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_outputs", {21'd0, imem_req, ir_load, dmem_req, dmem_we, rf_we, link_we,
                                    pc_we, pc_src, halted, bus_error}, 32'd0);
        chk("rst_mid_mem_state", 32'(state_o), 32'(FETCH));
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b1;

        // Fetch timeout: 16 wait cycles then ERROR.
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("timeout_wait%0d_state", k), 32'(state_o), 32'(FETCH));
            chk($sformatf("timeout_wait%0d_imem_req", k), 32'(imem_req), 32'd1);
            @(posedge clk); #1;
        end
        chk("timeout_error_state", 32'(state_o), 32'(ERROR));
        for (int k = 0; k < 4; k++) begin
            halt_req = k[0];
            @(negedge clk);
            chk($sformatf("error_sticky%0d", k), {29'd0, bus_error, halted, imem_req}, 32'd4);
            @(posedge clk); #1;
        end
        chk("error_state_held", 32'(state_o), 32'(ERROR));
        halt_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("error_cleared_by_reset", 32'(bus_error), 32'd0);
        chk("error_reset_state", 32'(state_o), 32'(FETCH));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle instruction sequencer for the MIPS datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Sits between the instruction/data memories, the combinational control decoder, PC register, IR and register file.
- Takes decoder class signals (branch, jump, load, store, reg write, link) and emits one-cycle enables plus memory request handshakes; retires exactly one instruction per pc_we pulse.

Parameters:
- MEM_TIMEOUT, 16: max wait cycles for imem_rdy/dmem_rdy before bus error; 0 disables the timeout.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- branch  in  1  decoder: conditional branch.
- jump  in  1  decoder: J/JAL.
- save_pc  in  1  decoder: link (JAL).
- data_mem_wren  in  1  decoder: store.
- mem_to_reg  in  1  decoder: load; any value other than 1'b1 (incl. Z/X) means not-load.
- reg_mem_wren  in  1  decoder: register write.
- branch_taken  in  1  ALU branch condition result.
- imem_rdy  in  1  instruction memory data valid.
- dmem_rdy  in  1  data memory access complete.
- halt_req  in  1  request to stop at the next instruction boundary.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  load IR (one-cycle pulse).
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write qualifier.
- rf_we  out  1  register file write pulse.
- link_we  out  1  write PC+4 to $31.
- pc_we  out  1  PC update and retire pulse.
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
- halted  out  1  in HALT state.
- bus_error  out  1  sticky memory timeout flag.
- state_o  out  3  current state encoding.

Behaviour:
- Reset: async on rst_n low. State FETCH, all outputs 0, wait counter 0, class flags 0, bus_error 0. Reset mid-operation abandons the instruction; no pulse completes.
- Outputs are decoded from state, latched class flags, imem_rdy/dmem_rdy and branch_taken. Decoder inputs are only sampled at the end of DECODE.
- FETCH:
  - imem_req=1 until imem_rdy.
  - Cycle with imem_rdy=1: ir_load=1; next state DECODE.
  - Wait counter increments on each cycle without imem_rdy. If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT: next state ERROR.
- DECODE:
  - One cycle; outputs idle.
  - Latch class flags: ld = (mem_to_reg===1), st = data_mem_wren, br, jp, lk = save_pc, wr = reg_mem_wren.
  - Priority: jp > br > st > ld > wr.
  - Next state EXEC.
- EXEC (one cycle):
  - jp: pc_we=1, pc_src=2, link_we=lk; retire.
  - br: pc_we=1, pc_src = branch_taken ? 1 : 0; retire.
  - st or ld: next state MEM.
  - wr: next state WB.
  - None of the above (NOP/unknown): pc_we=1, pc_src=0; retire.
- MEM:
  - dmem_req=1; dmem_we=st.
  - On dmem_rdy: store retires (pc_we=1, pc_src=0); load goes to WB.
  - Timeout rule as in FETCH; counter is cleared on every state entry.
- WB: rf_we=1, pc_we=1, pc_src=0; retire.
- Retire: next state HALT if halt_req=1 that cycle, otherwise FETCH.
- HALT: halted=1. Returns to FETCH in the first cycle halt_req=0. halt_req is ignored mid-instruction.
- ERROR:
  - bus_error=1, all enables 0.
  - Left only by reset; halt_req has no effect.
- Latency with zero-wait memory (imem_rdy high during FETCH), cycles from FETCH entry to pc_we:
  - R/I-type: 4.
  - Load: 5.
  - Store: 4.
  - Branch/jump: 3.
- Each memory wait cycle adds 1.
- pc_we is never asserted together with ir_load.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0].
  - cycle_cnt increments every cycle except in HALT/ERROR.
  - instr_cnt increments on each pc_we.
  - Both reset to 0 and wrap modulo 2^CNT_W.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Package seq_pkg:
  - State enum: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6.
  - PC_SRC_SEQ=0, PC_SRC_BR=1, PC_SRC_JMP=2.
- One sub-module seq_wait_timer:
  - Inputs: clear, enable.
  - Output: expired.
  - Parameterised by MEM_TIMEOUT.
  - Shared by FETCH and MEM.

Test Plan:
- ADD with imem_rdy=1 and wr=1 → ir_load at cycle 1, rf_we and pc_we together at cycle 4, pc_src=0; then back to FETCH.
- LW with 2 dmem wait cycles → dmem_req high 3 cycles with dmem_we=0; rf_we and pc_we at cycle 7.
- BEQ with branch_taken=1, then branch_taken=0 → pc_we at cycle 3 with pc_src=1, then pc_src=0; rf_we stays 0.
- JAL (jump=1, save_pc=1) → pc_we, pc_src=2 and link_we=1 in the same cycle (cycle 3).
- imem_rdy held 0 with MEM_TIMEOUT=16 → ERROR entered after 16 wait cycles; bus_error=1 and stays set through halt_req toggling until rst_n pulses low.
- halt_req raised during an SW MEM wait → store completes, pc_we pulses, halted=1 next cycle; halt_req drops → FETCH next cycle. Separately, rst_n low mid-MEM → all outputs 0 immediately.
